// File: rtl/fetch_pkg.sv
// Shared types and constants for the RV32I fetch stage.
package fetch_pkg;
  localparam int INSTR_W = 32;
  localparam int ENTRY_W = 2 * INSTR_W;
  localparam logic [INSTR_W-1:0] NOP_DEFAULT = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_REQ     = 2'd0,
    S_IDLE    = 2'd1,
    S_DISCARD = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [INSTR_W-1:0] pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  function automatic logic [INSTR_W-1:0] word_align(input logic [INSTR_W-1:0] a);
    return {a[INSTR_W-1:2], 2'b00};
  endfunction
endpackage

// File: rtl/instruction_buffer.sv
// Two-entry FIFO holding fetched {pc, instr} pairs; flush empties it in one cycle.
module instruction_buffer
  import fetch_pkg::*;
#(
  parameter int DATA_W = ENTRY_W
) (
  input  logic              gclk,
  input  logic              grst_n,
  input  logic              flush,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head_data,
  output logic [1:0]        count,
  output logic              full,
  output logic              empty
);
  logic [DATA_W-1:0] mem_q [2];
  logic [DATA_W-1:0] mem_d [2];
  logic              rd_ptr_q, rd_ptr_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic [1:0]        count_q, count_d;
  logic              do_push, do_pop;

  assign full      = (count_q == 2'd2);
  assign empty     = (count_q == 2'd0);
  assign count     = count_q;
  assign head_data = mem_q[rd_ptr_q];
  assign do_pop    = pop & ~empty;
  assign do_push   = push & (~full | do_pop);

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = ~wr_ptr_q;
      end
      if (do_pop) rd_ptr_d = ~rd_ptr_q;
      count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end
endmodule

// File: rtl/instruction_fetch_unit.sv
// RV32I fetch stage: owns the PC, drives busywait reads, buffers two words for decode
// and handles redirects, including discarding a read that is still in flight.
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = NOP_DEFAULT
) (
  input  logic        CLK,
  input  logic        RESET,
  output logic [31:0] IMEM_ADDR,
  output logic        IMEM_READ,
  input  logic        IMEM_BUSYWAIT,
  input  logic [31:0] IMEM_INSTRUCTION,
  input  logic        BRANCH_TAKEN,
  input  logic [31:0] BRANCH_TARGET,
  input  logic        ID_READY,
  output logic        ID_VALID,
  output logic [31:0] ID_INSTRUCTION,
  output logic [31:0] ID_PC
);
  fetch_state_e state_q, state_d;
  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic [31:0]  pending_pc_q, pending_pc_d;
  logic [31:0]  target;
  logic [1:0]   buf_count, count_after;
  logic         buf_full, buf_empty;
  logic         req, done, in_flight, enq, deq;
  fetch_entry_t head, push_entry;

  // Reads are suppressed while reset is held so the first request lands after release.
  always_comb begin
    req = 1'b0;
    unique case (state_q)
      S_REQ:     req = ~buf_full;
      S_IDLE:    req = 1'b0;
      S_DISCARD: req = 1'b1;
      default:   req = 1'b0;
    endcase
    req = req & RESET;
  end

  assign done        = req & ~IMEM_BUSYWAIT;
  assign in_flight   = req & IMEM_BUSYWAIT;
  assign target      = word_align(BRANCH_TARGET);
  assign enq         = (state_q == S_REQ) & done & ~BRANCH_TAKEN;
  assign deq         = ~buf_empty & ID_READY & ~BRANCH_TAKEN;
  assign count_after = buf_count + {1'b0, enq} - {1'b0, deq};
  assign push_entry  = '{pc: fetch_pc_q, instr: IMEM_INSTRUCTION};

  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    pending_pc_d = pending_pc_q;
    if (BRANCH_TAKEN) begin
      // An in-flight read cannot be cancelled; park the target until it completes.
      if (in_flight) begin
        pending_pc_d = target;
        state_d      = S_DISCARD;
      end else begin
        fetch_pc_d = target;
        state_d    = S_REQ;
      end
    end else begin
      unique case (state_q)
        S_REQ: begin
          if (done) fetch_pc_d = fetch_pc_q + 32'd4;
          if (count_after == 2'd2) state_d = S_IDLE;
        end
        S_IDLE: begin
          if (count_after != 2'd2) state_d = S_REQ;
        end
        S_DISCARD: begin
          if (done) begin
            fetch_pc_d = pending_pc_q;
            state_d    = S_REQ;
          end
        end
        default: state_d = S_REQ;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q      <= S_REQ;
      fetch_pc_q   <= RESET_PC;
      pending_pc_q <= RESET_PC;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      pending_pc_q <= pending_pc_d;
    end
  end

  instruction_buffer #(
    .DATA_W(ENTRY_W)
  ) u_buf (
    .gclk      (CLK),
    .grst_n    (RESET),
    .flush     (BRANCH_TAKEN),
    .push      (enq),
    .push_data (push_entry),
    .pop       (deq),
    .head_data (head),
    .count     (buf_count),
    .full      (buf_full),
    .empty     (buf_empty)
  );

  assign IMEM_ADDR      = fetch_pc_q;
  assign IMEM_READ      = req;
  assign ID_VALID       = ~buf_empty;
  assign ID_INSTRUCTION = buf_empty ? NOP_INSTR : head.instr;
  assign ID_PC          = buf_empty ? 32'd0 : head.pc;
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench: stimulus pushes the expected program-order PC stream, a monitor
// pops it on every word decode accepts; directed phases pin down cycle timing.
module tb_instruction_fetch_unit;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [31:0] MEM_KEY  = 32'hA5A5_0000;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic [31:0] IMEM_ADDR;
  logic        IMEM_READ;
  logic        IMEM_BUSYWAIT;
  logic [31:0] IMEM_INSTRUCTION;
  logic        BRANCH_TAKEN = 1'b0;
  logic [31:0] BRANCH_TARGET = 32'd0;
  logic        ID_READY = 1'b1;
  logic        ID_VALID;
  logic [31:0] ID_INSTRUCTION;
  logic [31:0] ID_PC;

  logic [2:0]  busy_left = 3'd0;
  logic [2:0]  lat_fix = 3'd0;
  logic        lat_rand = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  int n_acc    = 0;
  logic [31:0] exp_q [$];

  instruction_fetch_unit #(
    .RESET_PC (RESET_PC),
    .NOP_INSTR(NOP)
  ) dut (
    .CLK             (CLK),
    .RESET           (RESET),
    .IMEM_ADDR       (IMEM_ADDR),
    .IMEM_READ       (IMEM_READ),
    .IMEM_BUSYWAIT   (IMEM_BUSYWAIT),
    .IMEM_INSTRUCTION(IMEM_INSTRUCTION),
    .BRANCH_TAKEN    (BRANCH_TAKEN),
    .BRANCH_TARGET   (BRANCH_TARGET),
    .ID_READY        (ID_READY),
    .ID_VALID        (ID_VALID),
    .ID_INSTRUCTION  (ID_INSTRUCTION),
    .ID_PC           (ID_PC)
  );

  always #5 CLK = ~CLK;

  // Memory: each request is busy for busy_left cycles, data is a keyed function of the address.
  assign IMEM_BUSYWAIT    = IMEM_READ && (busy_left != 3'd0);
  assign IMEM_INSTRUCTION = IMEM_ADDR ^ MEM_KEY;

  always @(posedge CLK) begin
    if (!RESET)
      busy_left <= lat_rand ? 3'($urandom_range(0, 3)) : lat_fix;
    else if (IMEM_READ) begin
      if (busy_left != 3'd0) busy_left <= busy_left - 3'd1;
      else busy_left <= lat_rand ? 3'($urandom_range(0, 3)) : lat_fix;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // After a reset or redirect, decode must see target, target+4, ... in order.
  task automatic expect_from(input logic [31:0] pc);
    logic [31:0] p;
    p = pc;
    exp_q.delete();
    for (int i = 0; i < 512; i++) begin
      exp_q.push_back(p);
      p = p + 32'd4;
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic samp();
    @(negedge CLK);
  endtask

  task automatic monitor();
    logic [31:0] prev_addr;
    logic        prev_if;
    logic [31:0] e;
    prev_if   = 1'b0;
    prev_addr = 32'd0;
    forever begin
      @(negedge CLK);
      if (!RESET) begin
        prev_if = 1'b0;
      end else begin
        if (prev_if) begin
          chk("addr_hold", IMEM_ADDR, prev_addr);
          chkb("read_hold", IMEM_READ, 1'b1);
        end
        prev_if   = IMEM_READ && IMEM_BUSYWAIT;
        prev_addr = IMEM_ADDR;
        if (!ID_VALID) begin
          chk("idle_nop", ID_INSTRUCTION, NOP);
          chk("idle_pc", ID_PC, 32'd0);
        end else if (ID_READY && !BRANCH_TAKEN) begin
          chkb("sb_nonempty", exp_q.size() != 0, 1'b1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("sb_pc", ID_PC, e);
            chk("sb_instr", ID_INSTRUCTION, e ^ MEM_KEY);
            n_acc++;
          end
        end
      end
    end
  endtask

  initial begin
    logic        got;
    int          nw;
    int          since_br;
    int          a0;
    logic [31:0] t;

    fork
      monitor();
    join_none

    // Reset state, then zero-wait streaming.
    repeat (3) tick();
    samp();
    chkb("rst_read", IMEM_READ, 1'b0);
    chkb("rst_valid", ID_VALID, 1'b0);
    chk("rst_instr", ID_INSTRUCTION, NOP);
    chk("rst_pc", ID_PC, 32'd0);
    chk("rst_addr", IMEM_ADDR, RESET_PC);
    tick();
    RESET = 1'b1;
    expect_from(RESET_PC);
    samp();
    chkb("first_read", IMEM_READ, 1'b1);
    chkb("first_novalid", ID_VALID, 1'b0);
    chk("first_nop", ID_INSTRUCTION, NOP);
    for (int i = 0; i < 8; i++) begin
      tick();
      samp();
      chkb("stream_valid", ID_VALID, 1'b1);
      chk("stream_pc", ID_PC, 32'(4 * i));
    end

    // Three busy cycles per read: one word every four cycles.
    tick();
    RESET = 1'b0;
    lat_fix = 3'd3;
    tick();
    RESET = 1'b1;
    expect_from(RESET_PC);
    for (int j = 0; j <= 12; j++) begin
      samp();
      chkb("busy_valid", ID_VALID, (j > 0) && (j % 4 == 0));
      if ((j > 0) && (j % 4 == 0)) chk("busy_pc", ID_PC, 32'((j / 4 - 1) * 4));
      tick();
    end

    // Decode stalled: buffer fills, reads stop, then drains in order.
    RESET = 1'b0;
    lat_fix = 3'd0;
    ID_READY = 1'b0;
    tick();
    RESET = 1'b1;
    expect_from(RESET_PC);
    for (int j = 0; j < 10; j++) begin
      samp();
      if (j >= 1) begin
        chkb("stall_valid", ID_VALID, 1'b1);
        chk("stall_pc", ID_PC, 32'd0);
      end
      if (j >= 2) chkb("stall_noread", IMEM_READ, 1'b0);
      tick();
    end
    ID_READY = 1'b1;
    for (int k = 0; k < 4; k++) begin
      samp();
      chkb("drain_valid", ID_VALID, 1'b1);
      chk("drain_pc", ID_PC, 32'(4 * k));
      tick();
    end

    // Redirect in the same cycle a zero-wait read completes; low target bits ignored.
    BRANCH_TAKEN = 1'b1;
    BRANCH_TARGET = 32'h0000_0102;
    expect_from(32'h0000_0100);
    samp();
    chkb("br0_read", IMEM_READ, 1'b1);
    chkb("br0_nobusy", IMEM_BUSYWAIT, 1'b0);
    tick();
    BRANCH_TAKEN = 1'b0;
    samp();
    chkb("br0_flushed", ID_VALID, 1'b0);
    chk("br0_addr", IMEM_ADDR, 32'h0000_0100);
    tick();
    samp();
    chkb("br0_valid", ID_VALID, 1'b1);
    chk("br0_pc", ID_PC, 32'h0000_0100);
    tick();

    // Two redirects while a busy read is outstanding: latest wins, in-flight word dropped.
    RESET = 1'b0;
    lat_fix = 3'd3;
    tick();
    RESET = 1'b1;
    expect_from(RESET_PC);
    samp();
    chkb("disc_busy0", IMEM_BUSYWAIT, 1'b1);
    tick();
    BRANCH_TAKEN = 1'b1;
    BRANCH_TARGET = 32'h0000_0200;
    expect_from(32'h0000_0200);
    samp();
    chkb("disc_inflight", IMEM_BUSYWAIT, 1'b1);
    chkb("no_200", IMEM_ADDR != 32'h0000_0200, 1'b1);
    tick();
    BRANCH_TARGET = 32'h0000_0300;
    expect_from(32'h0000_0300);
    samp();
    chk("disc_addr_held", IMEM_ADDR, RESET_PC);
    tick();
    BRANCH_TAKEN = 1'b0;
    samp();
    chk("disc_addr_held2", IMEM_ADDR, RESET_PC);
    chkb("disc_complete", IMEM_BUSYWAIT, 1'b0);
    chkb("disc_novalid", ID_VALID, 1'b0);
    tick();
    samp();
    chk("disc_newaddr", IMEM_ADDR, 32'h0000_0300);
    got = 1'b0;
    nw = 0;
    for (int w = 0; w < 10 && !got; w++) begin
      tick();
      samp();
      nw++;
      chkb("no_200", IMEM_ADDR != 32'h0000_0200, 1'b1);
      if (ID_VALID) got = 1'b1;
    end
    chkb("disc_got", got, 1'b1);
    chk("disc_lat", 32'(nw), 32'd4);
    chk("disc_pc", ID_PC, 32'h0000_0300);

    // Reset pulsed during a busy read of 0x304.
    tick();
    RESET = 1'b0;
    lat_fix = 3'd0;
    expect_from(RESET_PC);
    samp();
    chkb("rst2_read", IMEM_READ, 1'b0);
    chkb("rst2_valid", ID_VALID, 1'b0);
    chk("rst2_addr", IMEM_ADDR, RESET_PC);
    chk("rst2_instr", ID_INSTRUCTION, NOP);
    tick();
    RESET = 1'b1;
    samp();
    chkb("rst2_novalid", ID_VALID, 1'b0);
    chkb("rst2_read1", IMEM_READ, 1'b1);
    tick();
    samp();
    chkb("rst2_valid1", ID_VALID, 1'b1);
    chk("rst2_pc", ID_PC, RESET_PC);

    // PC wrap from the top of the address space.
    tick();
    BRANCH_TAKEN = 1'b1;
    BRANCH_TARGET = 32'hFFFF_FFFC;
    expect_from(32'hFFFF_FFFC);
    tick();
    BRANCH_TAKEN = 1'b0;
    samp();
    chk("wrap_addr0", IMEM_ADDR, 32'hFFFF_FFFC);
    chkb("wrap_novalid", ID_VALID, 1'b0);
    tick();
    samp();
    chk("wrap_addr1", IMEM_ADDR, 32'd0);
    chk("wrap_pc0", ID_PC, 32'hFFFF_FFFC);
    tick();
    samp();
    chk("wrap_pc1", ID_PC, 32'd0);
    chk("wrap_addr2", IMEM_ADDR, 32'd4);

    // Random latency, backpressure, redirects and occasional resets.
    lat_rand = 1'b1;
    since_br = 0;
    for (int c = 0; c < 3000; c++) begin
      tick();
      BRANCH_TAKEN = 1'b0;
      if (!RESET) begin
        RESET = 1'b1;
      end else if ($urandom_range(0, 399) == 0) begin
        RESET = 1'b0;
        expect_from(RESET_PC);
      end else if (since_br >= 100 || $urandom_range(0, 11) == 0) begin
        t = $urandom();
        if ($urandom_range(0, 3) == 0) t = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        BRANCH_TAKEN = 1'b1;
        BRANCH_TARGET = t;
        expect_from({t[31:2], 2'b00});
        since_br = 0;
      end else begin
        since_br++;
      end
      ID_READY = ($urandom_range(0, 3) != 0);
    end

    // Drain with decode always ready: words must keep flowing.
    tick();
    BRANCH_TAKEN = 1'b0;
    RESET = 1'b1;
    ID_READY = 1'b1;
    a0 = n_acc;
    repeat (40) tick();
    samp();
    chkb("drain_progress", (n_acc - a0) >= 8, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
